// File: rtl/byte_stripe_scheduler.sv
// Purpose : two-lane byte striper; runs a COM-character alignment preamble, then round-robins valid bytes onto lane0/lane1.
// Latency : 1 clk2f cycle from accepted datain to lane0/lane1 (outputs registered on the accepting edge).
// Backpressure: in_ready follows lane_ready[lane_sel] in ACTIVE only; a stalled lane blocks input, the other lane is ignored.
//
// Ports:
//   clk2f, reset      - single clock, synchronous active-high reset
//   datain[8:0]       - {valid, byte} from the packet source
//   lane_ready[1:0]   - per-lane accept strobe from the serializers
//   resync            - level, forces the preamble to rerun
//   in_ready          - combinational accept for datain
//   lane0/lane1[8:0]  - registered {valid, byte} per lane
//   lane_sel          - lane that takes the next accepted byte
//   sync_done         - high while striping (ACTIVE)
//   byte_count[15:0]  - accepted data bytes, wraps at 16 bits
//
// Optional build macro STRIPE_PAD_EN: when defined, an idle cycle with lane_sel=1
// pushes a PAD_CHAR onto lane1 so bursts always end lane-balanced. The PAD_CHAR
// parameter only exists in that build.

module byte_stripe_scheduler #(
    parameter int unsigned SYNC_CYCLES = 4,
    parameter logic [7:0]  COM_CHAR    = 8'hBC
`ifdef STRIPE_PAD_EN
    ,
    parameter logic [7:0]  PAD_CHAR    = 8'hF7
`endif
) (
    input  logic        clk2f,
    input  logic        reset,
    input  logic [8:0]  datain,
    input  logic [1:0]  lane_ready,
    input  logic        resync,
    output logic        in_ready,
    output logic [8:0]  lane0,
    output logic [8:0]  lane1,
    output logic        lane_sel,
    output logic        sync_done,
    output logic [15:0] byte_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // Counter value on which the final sync cycle is accepted.
    localparam logic [7:0] SYNC_LAST = 8'(SYNC_CYCLES - 1);

    state_t      state_q;
    logic [7:0]  sync_cnt_q;
    logic [8:0]  lane0_q;
    logic [8:0]  lane1_q;
    logic        lane_sel_q;
    logic        sync_done_q;
    logic [15:0] byte_count_q;
    logic        xfer;

    // A resync request in ACTIVE closes the input that very cycle; reset
    // gating keeps the source from seeing a handshake that will be dropped.
    assign in_ready = !reset && (state_q == ST_ACTIVE) && !resync && lane_ready[lane_sel_q];
    assign xfer     = datain[8] && in_ready;

    always_ff @(posedge clk2f) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sync_cnt_q   <= 8'd0;
            lane0_q      <= 9'h000;
            lane1_q      <= 9'h000;
            lane_sel_q   <= 1'b0;
            sync_done_q  <= 1'b0;
            byte_count_q <= 16'd0;
        end else begin
            // Lanes carry nothing unless a branch below drives them.
            lane0_q <= 9'h000;
            lane1_q <= 9'h000;
            case (state_q)
                ST_IDLE: begin
                    state_q    <= ST_SYNC;
                    sync_cnt_q <= 8'd0;
                end
                ST_SYNC: begin
                    if (resync) begin
                        sync_cnt_q <= 8'd0;
                    end else if (lane_ready == 2'b11) begin
                        // Both lanes must take the COM char together to stay aligned.
                        lane0_q <= {1'b1, COM_CHAR};
                        lane1_q <= {1'b1, COM_CHAR};
                        if (sync_cnt_q == SYNC_LAST) begin
                            state_q     <= ST_ACTIVE;
                            sync_cnt_q  <= 8'd0;
                            lane_sel_q  <= 1'b0;
                            sync_done_q <= 1'b1;
                        end else begin
                            sync_cnt_q <= sync_cnt_q + 8'd1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (resync) begin
                        state_q     <= ST_SYNC;
                        sync_cnt_q  <= 8'd0;
                        lane_sel_q  <= 1'b0;
                        sync_done_q <= 1'b0;
                    end else if (xfer) begin
                        if (lane_sel_q) begin
                            lane1_q <= datain;
                        end else begin
                            lane0_q <= datain;
                        end
                        lane_sel_q   <= !lane_sel_q;
                        byte_count_q <= byte_count_q + 16'd1;
                    end
`ifdef STRIPE_PAD_EN
                    else if (lane_sel_q && !datain[8] && lane_ready[1]) begin
                        // Idle after an odd byte: pad lane1 to rebalance.
                        lane1_q    <= {1'b1, PAD_CHAR};
                        lane_sel_q <= 1'b0;
                    end
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign lane0      = lane0_q;
    assign lane1      = lane1_q;
    assign lane_sel   = lane_sel_q;
    assign sync_done  = sync_done_q;
    assign byte_count = byte_count_q;

endmodule

// File: doc/byte_stripe_scheduler.md
# byte_stripe_scheduler

Sequences the two-lane byte-striping datapath: accepts a stream of 9-bit words (bit 8 = valid, bits 7:0 = byte) in the clk2f domain, runs a lane-alignment preamble after reset, then round-robins valid bytes onto lane0 and lane1 under per-lane backpressure. It sits between the packet source and the per-lane serializers. It owns the lane pointer, the sync sequence and the input handshake; the lanes only consume.

## Interface
- SYNC_CYCLES, 4: number of accepted sync cycles before ACTIVE (range 1..255).
- COM_CHAR, 8'hBC: sync byte driven on both lanes during SYNC.
- PAD_CHAR, 8'hF7: balancing byte (STRIPE_PAD_EN only).
- clk2f  in  1: single clock, all logic on rising edge.
- reset  in  1: one clock; reset is synchronous and active-high.
- datain  in  9: bit 8 valid, bits 7:0 byte.
- lane_ready  in  2: bit n = lane n can accept a word this cycle.
- resync  in  1: level; forces return to SYNC.
- in_ready  out  1: combinational; datain accepted when datain[8] & in_ready.
- lane0  out  9: registered {valid, byte} to lane 0.
- lane1  out  9: registered {valid, byte} to lane 1.
- lane_sel  out  1: registered lane pointer (lane for next accepted byte).
- sync_done  out  1: registered, high while in ACTIVE.
- byte_count  out  16: registered count of accepted data bytes.

## Operation
- States: IDLE, SYNC, ACTIVE. Reset forces IDLE; IDLE -> SYNC unconditionally next cycle.
- SYNC: in_ready=0. Cycle with lane_ready==2'b11: lane0=lane1={1,COM_CHAR}, sync counter +1; otherwise both lanes 9'h000, counter holds. On the cycle the counter reaches SYNC_CYCLES -> ACTIVE, counter cleared, lane_sel=0.
- ACTIVE: in_ready = lane_ready[lane_sel]. Transfer (datain[8] & in_ready): lane[lane_sel] <= datain, other lane <= 9'h000, lane_sel toggles, byte_count +1 (wraps 16'hFFFF -> 0). No transfer: both lanes 9'h000, lane_sel holds (unless pad, see Configuration).
- datain[8]=0 is never a transfer; byte bits ignored.
- resync=1 in ACTIVE: next state SYNC, in_ready forced 0 that cycle, lane_sel cleared, byte_count kept. resync in IDLE/SYNC: ignored except SYNC counter restarts at 0.
- Only one lane carries valid data per cycle in ACTIVE; both lanes valid only in SYNC.

## Timing
- Reset values: lane0=lane1=9'h000, lane_sel=0, sync_done=0, byte_count=0, in_ready=0, state IDLE.
- Minimum time from reset release to first in_ready: 1 (IDLE) + SYNC_CYCLES cycles.
- Latency datain -> laneN: 1 clk2f cycle (output registered on the accepting edge).
- in_ready depends combinationally on lane_ready and state; no combinational path from datain to any output.
- reset asserted mid-transfer: the transfer on that edge is discarded, all outputs return to reset values on that edge.
- reset and resync together: reset wins.
- lane_ready[lane_sel]=0 stalls; the other lane's readiness is irrelevant in ACTIVE.

## Configuration
- STRIPE_PAD_EN defined: in ACTIVE, a cycle with lane_sel=1, datain[8]=0, lane_ready[1]=1 drives lane1={1,PAD_CHAR}, lane0=9'h000, lane_sel <= 0; byte_count not incremented. Keeps lanes balanced at burst end.
- STRIPE_PAD_EN undefined: no pad insertion; lane_sel holds at 1 across idle gaps; PAD_CHAR unused.

## Test plan
- Reset 3 cycles, lane_ready=2'b11 -> lane0=lane1=9'h1BC for exactly 4 cycles, then sync_done=1, in_ready=1.
- ACTIVE, datain 9'h10C,9'h10F,9'h111,9'h117 back-to-back -> lane0 gets 9'h10C then 9'h111, lane1 9'h10F then 9'h117 on alternate cycles, byte_count=4.
- lane_ready=2'b10 with lane_sel=0, datain=9'h121 held 3 cycles -> in_ready=0, lanes 9'h000; on lane_ready=2'b11 byte goes to lane0 one cycle later.
- Odd burst 9'h10C,9'h10F,9'h111 then datain=9'h011 -> with STRIPE_PAD_EN lane1=9'h1F7, lane_sel=0, byte_count=3; without it lanes 9'h000, lane_sel stays 1.
- resync pulse in ACTIVE with byte_count=5 -> SYNC_CYCLES cycles of 9'h1BC on both lanes, lane_sel=0, byte_count still 5; reset mid-SYNC -> all outputs zero next edge.
- byte_count preset by 65535 transfers -> next transfer wraps byte_count to 0.
